// File: rtl/mem_wb_if.sv
// mem_wb_if: bundles the MEM-stage request, data-memory response and writeback
// result signals of the MEM/WB stage.
//   master : upstream side, drives mem_* / flush / dmem_*, observes wb_* / stallreq
//   slave  : the mem_wb block itself
interface mem_wb_if;
  logic        mem_valid;
  logic        mem_wreg;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_load;
  logic [2:0]  mem_ld_op;
  logic [1:0]  mem_addr_lo;
  logic        flush;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        stallreq;
  logic        wb_adel;

  modport master (
    output mem_valid, mem_wreg, mem_waddr, mem_wdata, mem_load, mem_ld_op, mem_addr_lo,
    output flush, dmem_rvalid, dmem_rdata,
    input  wb_we, wb_waddr, wb_wdata, stallreq, wb_adel
  );

  modport slave (
    input  mem_valid, mem_wreg, mem_waddr, mem_wdata, mem_load, mem_ld_op, mem_addr_lo,
    input  flush, dmem_rvalid, dmem_rdata,
    output wb_we, wb_waddr, wb_wdata, stallreq, wb_adel
  );
endinterface

// File: rtl/mem_wb.sv
// mem_wb: MEM/WB pipeline stage. Non-load results retire one cycle after being
// presented; loads park in WAIT until the data memory answers, then the loaded
// word is lane-extracted and written back. A flush during WAIT with the response
// still outstanding moves to DRAIN so the late response is swallowed.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - mem_wb_if.slave (MEM request, flush, dmem response, wb outputs, stallreq)
// Configuration: define MISALIGN_EXC_EN to turn misaligned LW/LH/LHU into a
// wb_adel pulse with no register write; otherwise wb_adel is tied 0.
module mem_wb (
  input  logic     clk,
  input  logic     rst,
  mem_wb_if.slave  bus
);

  localparam logic [2:0] OpLw  = 3'd0;
  localparam logic [2:0] OpLb  = 3'd1;
  localparam logic [2:0] OpLbu = 3'd2;
  localparam logic [2:0] OpLh  = 3'd3;
  localparam logic [2:0] OpLhu = 3'd4;

  typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

  state_e      state_q, state_d;
  logic        wreg_q;
  logic [4:0]  waddr_q;
  logic [2:0]  ld_op_q;
  logic [1:0]  addr_lo_q;
  logic        capture;
  logic        we_q, we_d;
  logic [4:0]  wb_waddr_q, wb_waddr_d;
  logic [31:0] wb_wdata_q, wb_wdata_d;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_data;

`ifdef MISALIGN_EXC_EN
  logic adel_q, adel_d;
  logic misal;
  assign misal = (((ld_op_q == OpLh) || (ld_op_q == OpLhu)) && addr_lo_q[0]) ||
                 ((ld_op_q == OpLw) && (addr_lo_q != 2'b00));
`endif

  // Big-endian lanes: addr_lo 0 selects the most significant byte.
  always_comb begin
    lane_b = 8'h00;
    unique case (addr_lo_q)
      2'd0: lane_b = bus.dmem_rdata[31:24];
      2'd1: lane_b = bus.dmem_rdata[23:16];
      2'd2: lane_b = bus.dmem_rdata[15:8];
      2'd3: lane_b = bus.dmem_rdata[7:0];
      default: lane_b = 8'h00;
    endcase
    lane_h = addr_lo_q[1] ? bus.dmem_rdata[15:0] : bus.dmem_rdata[31:16];
    case (ld_op_q)
      OpLw:    ld_data = bus.dmem_rdata;
      OpLb:    ld_data = {{24{lane_b[7]}}, lane_b};
      OpLbu:   ld_data = {24'h0, lane_b};
      OpLh:    ld_data = {{16{lane_h[15]}}, lane_h};
      OpLhu:   ld_data = {16'h0, lane_h};
      default: ld_data = 32'h0;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wreg_q     <= 1'b0;
      waddr_q    <= 5'd0;
      ld_op_q    <= 3'd0;
      addr_lo_q  <= 2'd0;
      we_q       <= 1'b0;
      wb_waddr_q <= 5'd0;
      wb_wdata_q <= 32'h0;
`ifdef MISALIGN_EXC_EN
      adel_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      wb_waddr_q <= wb_waddr_d;
      wb_wdata_q <= wb_wdata_d;
`ifdef MISALIGN_EXC_EN
      adel_q     <= adel_d;
`endif
      if (capture) begin
        wreg_q    <= bus.mem_wreg;
        waddr_q   <= bus.mem_waddr;
        ld_op_q   <= bus.mem_ld_op;
        addr_lo_q <= bus.mem_addr_lo;
      end
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.mem_valid && !bus.flush && bus.mem_load) state_d = StWait;
      end
      StWait: begin
        if (bus.flush)            state_d = bus.dmem_rvalid ? StIdle : StDrain;
        else if (bus.dmem_rvalid) state_d = StIdle;
      end
      StDrain: begin
        if (bus.dmem_rvalid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: capture strobe, next writeback values, stall request.
  always_comb begin
    capture    = 1'b0;
    we_d       = 1'b0;
    wb_waddr_d = wb_waddr_q;
    wb_wdata_d = wb_wdata_q;
`ifdef MISALIGN_EXC_EN
    adel_d     = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.mem_valid && !bus.flush) begin
          if (bus.mem_load) begin
            capture = 1'b1;
          end else begin
            we_d       = bus.mem_wreg;
            wb_waddr_d = bus.mem_waddr;
            wb_wdata_d = bus.mem_wdata;
          end
        end
      end
      StWait: begin
        if (bus.dmem_rvalid && !bus.flush) begin
`ifdef MISALIGN_EXC_EN
          if (misal) begin
            adel_d = 1'b1;
          end else begin
            we_d       = wreg_q;
            wb_waddr_d = waddr_q;
            wb_wdata_d = ld_data;
          end
`else
          we_d       = wreg_q;
          wb_waddr_d = waddr_q;
          wb_wdata_d = ld_data;
`endif
        end
      end
      default: ;
    endcase
  end

  assign bus.stallreq = (state_q != StIdle) && !bus.dmem_rvalid;
  assign bus.wb_we    = we_q;
  assign bus.wb_waddr = wb_waddr_q;
  assign bus.wb_wdata = wb_wdata_q;
`ifdef MISALIGN_EXC_EN
  assign bus.wb_adel  = adel_q;
`else
  assign bus.wb_adel  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb.sv
module tb_mem_wb;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [36:0] exp_q[$];

  mem_wb_if bus ();

  mem_wb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference load extraction, written independently of the RTL lane mux.
  function automatic logic [31:0] ld_model(input logic [2:0] op, input logic [1:0] lo,
                                            input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> (8 * (3 - int'(lo))));
    h = 16'(d >> (lo[1] ? 0 : 16));
    case (op)
      3'd0:    return d;
      3'd1:    return {{24{b[7]}}, b};
      3'd2:    return {24'h0, b};
      3'd3:    return {{16{h[15]}}, h};
      3'd4:    return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  // Scoreboard: every wb_we pulse must match the oldest expected retirement.
  always @(negedge clk) begin
    if (bus.wb_we === 1'b1) begin
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL sb_unexpected got=%h/%h exp=none", bus.wb_waddr, bus.wb_wdata);
      end
      if (exp_q.size() > 0) begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("sb_waddr", 32'(bus.wb_waddr), 32'(e[36:32]));
        chk("sb_wdata", bus.wb_wdata, e[31:0]);
      end
    end
  end

  task automatic alu_op(input logic wreg, input logic [4:0] wa, input logic [31:0] wd);
    bus.mem_valid = 1'b1; bus.mem_load = 1'b0; bus.mem_wreg = wreg;
    bus.mem_waddr = wa;   bus.mem_wdata = wd;
    if (wreg) exp_q.push_back({wa, wd});
    tick();
    bus.mem_valid = 1'b0;
    chk("alu_we", 32'(bus.wb_we), 32'(wreg));
    if (wreg) begin
      chk("alu_waddr", 32'(bus.wb_waddr), 32'(wa));
      chk("alu_wdata", bus.wb_wdata, wd);
    end
  endtask

  task automatic start_load(input logic [2:0] op, input logic [1:0] lo, input logic [4:0] wa);
    bus.mem_valid = 1'b1; bus.mem_load = 1'b1; bus.mem_wreg = 1'b1;
    bus.mem_waddr = wa;   bus.mem_ld_op = op;  bus.mem_addr_lo = lo;
    bus.mem_wdata = 32'hBAD0_BAD0;
    tick();
    bus.mem_valid = 1'b0; bus.mem_load = 1'b0;
  endtask

  // Full load: nstall WAIT cycles (with ignored upstream traffic), then response.
  task automatic do_load(input logic [2:0] op, input logic [1:0] lo, input logic [4:0] wa,
                         input logic [31:0] rd, input int nstall);
    logic [31:0] e;
    e = ld_model(op, lo, rd);
    start_load(op, lo, wa);
    exp_q.push_back({wa, e});
    chk("ld_we_after_accept", 32'(bus.wb_we), 32'd0);
    for (int i = 0; i < nstall; i++) begin
      bus.mem_valid = 1'b1; bus.mem_wreg = 1'b1; bus.mem_waddr = 5'd31;
      bus.mem_wdata = 32'hFEED_0000 + 32'(i);
      #1;
      chk("ld_stall", 32'(bus.stallreq), 32'd1);
      tick();
      bus.mem_valid = 1'b0;
    end
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = rd;
    #1;
    chk("ld_stall_rvalid", 32'(bus.stallreq), 32'd0);
    tick();
    bus.dmem_rvalid = 1'b0;
    chk("ld_we", 32'(bus.wb_we), 32'd1);
    chk("ld_wdata", bus.wb_wdata, e);
    chk("ld_adel", 32'(bus.wb_adel), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0;
    bus.mem_valid = 1'b0; bus.mem_wreg = 1'b0; bus.mem_waddr = 5'd0; bus.mem_wdata = 32'h0;
    bus.mem_load = 1'b0;  bus.mem_ld_op = 3'd0; bus.mem_addr_lo = 2'd0; bus.flush = 1'b0;
    bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'h0;

    // Asynchronous reset, observed before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_we", 32'(bus.wb_we), 32'd0);
    chk("rst_waddr", 32'(bus.wb_waddr), 32'd0);
    chk("rst_wdata", bus.wb_wdata, 32'h0);
    chk("rst_stall", 32'(bus.stallreq), 32'd0);
    chk("rst_adel", 32'(bus.wb_adel), 32'd0);
    @(negedge clk) rst = 1'b0;
    tick();

    // rvalid in IDLE is ignored.
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h1234_5678;
    #1 chk("idle_rvalid_stall", 32'(bus.stallreq), 32'd0);
    tick();
    bus.dmem_rvalid = 1'b0;
    chk("idle_rvalid_we", 32'(bus.wb_we), 32'd0);

    // ALU op, then pulse drops and values hold.
    alu_op(1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    chk("alu_we_drop", 32'(bus.wb_we), 32'd0);
    chk("alu_waddr_hold", 32'(bus.wb_waddr), 32'd5);
    chk("alu_wdata_hold", bus.wb_wdata, 32'hDEAD_BEEF);

    // Loads across ops and lanes.
    do_load(3'd1, 2'd2, 5'd7,  32'h1122_8344, 2);
    do_load(3'd4, 2'd0, 5'd8,  32'h8001_0000, 1);
    do_load(3'd0, 2'd0, 5'd9,  32'hCAFE_F00D, 0);
    do_load(3'd1, 2'd0, 5'd10, 32'h7F00_00FF, 1);
    do_load(3'd2, 2'd3, 5'd11, 32'h7F00_00FF, 2);
    do_load(3'd3, 2'd2, 5'd12, 32'h0000_9ABC, 1);
    do_load(3'd4, 2'd2, 5'd13, 32'h0000_9ABC, 0);
    do_load(3'd3, 2'd0, 5'd14, 32'h1234_0000, 1);
    do_load(3'd5, 2'd1, 5'd15, 32'hFFFF_FFFF, 1);

    // Flush in WAIT, response arrives later: DRAIN swallows it.
    start_load(3'd0, 2'd0, 5'd16);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("drain_stall0", 32'(bus.stallreq), 32'd1);
    tick();
    chk("drain_stall1", 32'(bus.stallreq), 32'd1);
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h5555_AAAA;
    #1 chk("drain_stall_rvalid", 32'(bus.stallreq), 32'd0);
    tick();
    bus.dmem_rvalid = 1'b0;
    chk("drain_we", 32'(bus.wb_we), 32'd0);
    chk("drain_idle_stall", 32'(bus.stallreq), 32'd0);
    alu_op(1'b1, 5'd17, 32'h0000_0017);

    // Flush in WAIT with same-cycle response: straight back to IDLE.
    start_load(3'd0, 2'd0, 5'd18);
    bus.flush = 1'b1; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h6666_6666;
    tick();
    bus.flush = 1'b0; bus.dmem_rvalid = 1'b0;
    chk("flush_rv_we", 32'(bus.wb_we), 32'd0);
    chk("flush_rv_idle", 32'(bus.stallreq), 32'd0);

    // Flush in IDLE beats mem_valid.
    bus.mem_valid = 1'b1; bus.mem_load = 1'b0; bus.mem_wreg = 1'b1;
    bus.mem_waddr = 5'd19; bus.mem_wdata = 32'h1919_1919; bus.flush = 1'b1;
    tick();
    bus.mem_valid = 1'b0; bus.flush = 1'b0;
    chk("idle_flush_we", 32'(bus.wb_we), 32'd0);
    chk("idle_flush_waddr", 32'(bus.wb_waddr), 32'd17);

    // wreg=0 and waddr=0 pass-through.
    alu_op(1'b0, 5'd3, 32'h3333_3333);
    alu_op(1'b1, 5'd0, 32'h0000_ABCD);

    // Reset mid-WAIT abandons the load.
    start_load(3'd0, 2'd0, 5'd20);
    #2 rst = 1'b1;
    #1;
    chk("rstw_we", 32'(bus.wb_we), 32'd0);
    chk("rstw_waddr", 32'(bus.wb_waddr), 32'd0);
    chk("rstw_wdata", bus.wb_wdata, 32'h0);
    chk("rstw_stall", 32'(bus.stallreq), 32'd0);
    #1 rst = 1'b0;
    tick();
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h2020_2020;
    #1 chk("rstw_rvalid_stall", 32'(bus.stallreq), 32'd0);
    tick();
    bus.dmem_rvalid = 1'b0;
    chk("rstw_rvalid_we", 32'(bus.wb_we), 32'd0);

    // Misaligned LW.
`ifdef MISALIGN_EXC_EN
    start_load(3'd0, 2'd1, 5'd21);
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h1234_5678;
    tick();
    bus.dmem_rvalid = 1'b0;
    chk("mis_we", 32'(bus.wb_we), 32'd0);
    chk("mis_adel", 32'(bus.wb_adel), 32'd1);
    tick();
    chk("mis_adel_drop", 32'(bus.wb_adel), 32'd0);
`else
    do_load(3'd0, 2'd1, 5'd21, 32'h1234_5678, 1);
    chk("mis_word", bus.wb_wdata, 32'h1234_5678);
`endif

    tick();
    tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
